kyber_poly_ram: RTL and testbench

// - Parametrised true dual-port RAM for Kyber polynomial coefficient storage; next generation of the NTT scratch RAM.
// - Adds over the previous generation: generic width/depth, selectable read latency, port enables with read-valid tags, write-collision arbitration and a hardware clear sequencer.
// - Sits between the NTT/poly-arith datapath (two butterfly ports) and the host load/unload path.

---
 rtl/kyber_pkg.sv | 16 +
 rtl/kyber_ram_clr_seq.sv | 88 ++++++++
 rtl/kyber_poly_ram.sv | 142 ++++++++++++++
 tb/tb_kyber_poly_ram.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, write-mode encodings and the RAM clear-sequencer state type.
package kyber_pkg;

    localparam int unsigned KYBER_N     = 256;
    localparam int unsigned KYBER_Q     = 3329;
    localparam int unsigned COEF_W      = 16;

    localparam int unsigned WRITE_FIRST = 0;
    localparam int unsigned READ_FIRST  = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_state_t;

endpackage

// File: rtl/kyber_ram_clr_seq.sv
// Clear sequencer for kyber_poly_ram: zeroes two words per cycle while busy and
// steers the memory write ports between the user and the sequencer.
module kyber_ram_clr_seq
    import kyber_pkg::*;
#(
    parameter int unsigned WIDTH      = COEF_W,
    parameter int unsigned AW         = 8,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             u_we_1_i,
    input  logic [AW-1:0]    u_addr_1_i,
    input  logic [WIDTH-1:0] u_din_1_i,
    input  logic             u_we_2_i,
    input  logic [AW-1:0]    u_addr_2_i,
    input  logic [WIDTH-1:0] u_din_2_i,
    output logic             busy_o,
    output logic             m_we_1_c_o,
    output logic [AW-1:0]    m_addr_1_c_o,
    output logic [WIDTH-1:0] m_din_1_c_o,
    output logic             m_we_2_c_o,
    output logic [AW-1:0]    m_addr_2_c_o,
    output logic [WIDTH-1:0] m_din_2_c_o
);

    localparam int unsigned CW = AW - 1;

    ram_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_ON_RST ? CLEAR : IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clr pulse always restarts the sweep from word pair 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (clr_i) begin
                    cnt_d = '0;
                end else if (cnt_q == {CW{1'b1}}) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Port 1 clears even addresses, port 2 odd ones; held off while rst is asserted.
    always_comb begin
        busy_c       = (state_q == CLEAR);
        busy_o       = busy_c;
        m_we_1_c_o   = u_we_1_i;
        m_addr_1_c_o = u_addr_1_i;
        m_din_1_c_o  = u_din_1_i;
        m_we_2_c_o   = u_we_2_i;
        m_addr_2_c_o = u_addr_2_i;
        m_din_2_c_o  = u_din_2_i;
        if (busy_c) begin
            m_we_1_c_o   = !rst;
            m_addr_1_c_o = {cnt_q, 1'b0};
            m_din_1_c_o  = '0;
            m_we_2_c_o   = !rst;
            m_addr_2_c_o = {cnt_q, 1'b1};
            m_din_2_c_o  = '0;
        end
    end

endmodule

// File: rtl/kyber_poly_ram.sv
// True dual-port coefficient RAM with selectable read latency, write-collision
// arbitration (port 1 wins) and a hardware clear sequencer.
module kyber_poly_ram
    import kyber_pkg::*;
#(
    parameter int unsigned WIDTH      = COEF_W,
    parameter int unsigned AW         = $clog2(KYBER_N),
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned WRITE_MODE = WRITE_FIRST,
    parameter string       INIT_FILE  = "",
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_1,
    input  logic             we_1,
    input  logic [AW-1:0]    addr_1,
    input  logic [WIDTH-1:0] din_1,
    output logic [WIDTH-1:0] dout_1,
    output logic             rvalid_1,
    input  logic             en_2,
    input  logic             we_2,
    input  logic [AW-1:0]    addr_2,
    input  logic [WIDTH-1:0] din_2,
    output logic [WIDTH-1:0] dout_2,
    output logic             rvalid_2,
    input  logic             clr,
    output logic             busy,
    output logic             coll
);

    localparam int unsigned DEPTH = 1 << AW;

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $fatal(1, "kyber_poly_ram: READ_LAT must be 1 or 2");
    end
    if (WRITE_MODE != WRITE_FIRST && WRITE_MODE != READ_FIRST) begin : g_bad_wm
        $fatal(1, "kyber_poly_ram: WRITE_MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             acc_1, acc_2, wr_1, wr_2, coll_c;
    logic [WIDTH-1:0] rd_1_c, rd_2_c;
    logic             m_we_1, m_we_2;
    logic [AW-1:0]    m_addr_1, m_addr_2;
    logic [WIDTH-1:0] m_din_1, m_din_2;
    logic             s1_v_1_q, s1_v_2_q, coll_q;
    logic [WIDTH-1:0] s1_d_1_q, s1_d_2_q;

    // Acceptance, collision detect and first-stage read data.
    always_comb begin
        acc_1  = en_1 && !busy;
        acc_2  = en_2 && !busy;
        wr_1   = acc_1 && we_1;
        wr_2   = acc_2 && we_2;
        coll_c = wr_1 && wr_2 && (addr_1 == addr_2);
        rd_1_c = mem_q[addr_1];
        rd_2_c = mem_q[addr_2];
        if (WRITE_MODE == WRITE_FIRST) begin
            if (wr_1) rd_1_c = din_1;
            if (wr_2) rd_2_c = coll_c ? din_1 : din_2;
        end
    end

    kyber_ram_clr_seq #(
        .WIDTH      (WIDTH),
        .AW         (AW),
        .CLR_ON_RST (CLR_ON_RST != 0)
    ) u_clr_seq (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .u_we_1_i     (en_1 && we_1),
        .u_addr_1_i   (addr_1),
        .u_din_1_i    (din_1),
        .u_we_2_i     (en_2 && we_2 && !coll_c),
        .u_addr_2_i   (addr_2),
        .u_din_2_i    (din_2),
        .busy_o       (busy),
        .m_we_1_c_o   (m_we_1),
        .m_addr_1_c_o (m_addr_1),
        .m_din_1_c_o  (m_din_1),
        .m_we_2_c_o   (m_we_2),
        .m_addr_2_c_o (m_addr_2),
        .m_din_2_c_o  (m_din_2)
    );

    // Plain block-RAM template; contents are deliberately not reset.
    always @(posedge clk) begin
        if (m_we_1) mem_q[m_addr_1] <= m_din_1;
        if (m_we_2) mem_q[m_addr_2] <= m_din_2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_1_q <= 1'b0;
            s1_v_2_q <= 1'b0;
            s1_d_1_q <= '0;
            s1_d_2_q <= '0;
            coll_q   <= 1'b0;
        end else begin
            s1_v_1_q <= acc_1;
            s1_v_2_q <= acc_2;
            if (acc_1) s1_d_1_q <= rd_1_c;
            if (acc_2) s1_d_2_q <= rd_2_c;
            coll_q   <= coll_c;
        end
    end

    assign coll = coll_q;

    if (READ_LAT == 2) begin : g_lat2
        logic             s2_v_1_q, s2_v_2_q;
        logic [WIDTH-1:0] s2_d_1_q, s2_d_2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_v_1_q <= 1'b0;
                s2_v_2_q <= 1'b0;
                s2_d_1_q <= '0;
                s2_d_2_q <= '0;
            end else begin
                s2_v_1_q <= s1_v_1_q;
                s2_v_2_q <= s1_v_2_q;
                if (s1_v_1_q) s2_d_1_q <= s1_d_1_q;
                if (s1_v_2_q) s2_d_2_q <= s1_d_2_q;
            end
        end

        assign rvalid_1 = s2_v_1_q;
        assign rvalid_2 = s2_v_2_q;
        assign dout_1   = s2_d_1_q;
        assign dout_2   = s2_d_2_q;
    end else begin : g_lat1
        assign rvalid_1 = s1_v_1_q;
        assign rvalid_2 = s1_v_2_q;
        assign dout_1   = s1_d_1_q;
        assign dout_2   = s1_d_2_q;
    end

endmodule

// File: tb/tb_kyber_poly_ram.sv
// Directed and model-checked bench for kyber_poly_ram: instance a is write-first
// with READ_LAT 1, instance b is read-first with READ_LAT 2, both on shared stimulus.
module tb_kyber_poly_ram;
    import kyber_pkg::*;

    logic        clk;
    logic        rst, clr;
    logic        en_1, we_1, en_2, we_2;
    logic [7:0]  addr_1, addr_2;
    logic [15:0] din_1, din_2;

    logic [15:0] a_dout_1, a_dout_2, b_dout_1, b_dout_2;
    logic        a_rvalid_1, a_rvalid_2, b_rvalid_1, b_rvalid_2;
    logic        a_busy, b_busy, a_coll, b_coll;

    int n_vec = 0;
    int n_err = 0;

    kyber_poly_ram #(.READ_LAT(1), .WRITE_MODE(0)) dut_a (
        .clk(clk), .rst(rst),
        .en_1(en_1), .we_1(we_1), .addr_1(addr_1), .din_1(din_1), .dout_1(a_dout_1), .rvalid_1(a_rvalid_1),
        .en_2(en_2), .we_2(we_2), .addr_2(addr_2), .din_2(din_2), .dout_2(a_dout_2), .rvalid_2(a_rvalid_2),
        .clr(clr), .busy(a_busy), .coll(a_coll)
    );

    kyber_poly_ram #(.READ_LAT(2), .WRITE_MODE(1)) dut_b (
        .clk(clk), .rst(rst),
        .en_1(en_1), .we_1(we_1), .addr_1(addr_1), .din_1(din_1), .dout_1(b_dout_1), .rvalid_1(b_rvalid_1),
        .en_2(en_2), .we_2(we_2), .addr_2(addr_2), .din_2(din_2), .dout_2(b_dout_2), .rvalid_2(b_rvalid_2),
        .clr(clr), .busy(b_busy), .coll(b_coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e1, input logic w1, input logic [7:0] a1, input logic [15:0] d1,
                         input logic e2, input logic w2, input logic [7:0] a2, input logic [15:0] d2);
        en_1 = e1; we_1 = w1; addr_1 = a1; din_1 = d1;
        en_2 = e2; we_2 = w2; addr_2 = a2; din_2 = d2;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    endtask

    // Reference model for the random phase (memory is all zero when it starts).
    logic        model_on = 1'b0;
    logic [15:0] mm [256];
    logic        m_w1, m_w2, m_cl, e_coll;
    logic [15:0] rf1, rf2, wf1, wf2;
    logic        ea_v_1, ea_v_2, eb_v_1, eb_v_2, sb_v_1, sb_v_2;
    logic [15:0] ea_d_1, ea_d_2, eb_d_1, eb_d_2, sb_d_1, sb_d_2;

    always @(posedge clk) begin
        if (model_on) begin
            m_w1 = en_1 && we_1;
            m_w2 = en_2 && we_2;
            m_cl = m_w1 && m_w2 && (addr_1 == addr_2);
            rf1  = mm[addr_1];
            rf2  = mm[addr_2];
            wf1  = m_w1 ? din_1 : rf1;
            wf2  = m_w2 ? (m_cl ? din_1 : din_2) : rf2;
            if (m_w2 && !m_cl) mm[addr_2] = din_2;
            if (m_w1) mm[addr_1] = din_1;
            e_coll = m_cl;
            ea_v_1 = en_1; if (en_1) ea_d_1 = wf1;
            ea_v_2 = en_2; if (en_2) ea_d_2 = wf2;
            eb_v_1 = sb_v_1; if (sb_v_1) eb_d_1 = sb_d_1;
            eb_v_2 = sb_v_2; if (sb_v_2) eb_d_2 = sb_d_2;
            sb_v_1 = en_1; if (en_1) sb_d_1 = rf1;
            sb_v_2 = en_2; if (en_2) sb_d_2 = rf2;
        end
    end

    int n;

    initial begin
        rst = 1'b1; clr = 1'b0;
        idle();
        step(); step();
        chk("rst_busy_a", a_busy, 1);
        chk("rst_busy_b", b_busy, 1);
        chk("rst_rv_a1", a_rvalid_1, 0);
        chk("rst_rv_b2", b_rvalid_2, 0);
        chk("rst_dout_a1", a_dout_1, 0);
        chk("rst_dout_b2", b_dout_2, 0);
        chk("rst_coll", a_coll, 0);

        // Power-on clear lasts 128 cycles after rst release.
        rst = 1'b0;
        n = 0;
        while (a_busy && n < 300) begin step(); n++; end
        chk("clr_len_rst", n, 128);

        // Write then cross-port read.
        drive(1, 1, 8'h10, 16'h0ABC, 0, 0, 8'h00, 16'h0000); step();
        chk("wr_a_rv1", a_rvalid_1, 1);
        chk("wr_a_dout1_wf", a_dout_1, 16'h0ABC);
        chk("wr_b_rv1_lat2", b_rvalid_1, 0);
        drive(0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'h0000); step();
        chk("rd_a_rv2", a_rvalid_2, 1);
        chk("rd_a_dout2", a_dout_2, 16'h0ABC);
        chk("rd_a_rv1_off", a_rvalid_1, 0);
        chk("rd_a_dout1_hold", a_dout_1, 16'h0ABC);
        chk("wr_b_rv1", b_rvalid_1, 1);
        chk("wr_b_dout1_rf", b_dout_1, 16'h0000);
        idle(); step();
        chk("rd_a_rv2_off", a_rvalid_2, 0);
        chk("rd_b_rv2", b_rvalid_2, 1);
        chk("rd_b_dout2", b_dout_2, 16'h0ABC);

        // Same-address write collision.
        drive(1, 1, 8'h20, 16'h0111, 1, 1, 8'h20, 16'h0222); step();
        chk("coll_a", a_coll, 1);
        chk("coll_b", b_coll, 1);
        chk("coll_a_dout2", a_dout_2, 16'h0111);
        idle(); step();
        chk("coll_a_pulse", a_coll, 0);
        chk("coll_b_dout2_old", b_dout_2, 16'h0000);
        drive(0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 16'h0000); step();
        chk("coll_rd_a", a_dout_2, 16'h0111);
        idle(); step();
        chk("coll_rd_b", b_dout_2, 16'h0111);

        // Port 1 overwrites while port 2 reads the same address.
        drive(1, 1, 8'h30, 16'h0111, 0, 0, 8'h00, 16'h0000); step();
        drive(1, 1, 8'h30, 16'h0333, 1, 0, 8'h30, 16'h0000); step();
        chk("xrd_a_dout1", a_dout_1, 16'h0333);
        chk("xrd_a_dout2", a_dout_2, 16'h0111);
        idle(); step();
        chk("xrd_b_dout1", b_dout_1, 16'h0111);
        chk("xrd_b_dout2", b_dout_2, 16'h0111);

        // Preload boundary addresses, then clear with a user read in the same cycle.
        drive(1, 1, 8'h00, 16'h0001, 1, 1, 8'hFF, 16'h0FFF); step();
        drive(1, 1, 8'h7F, 16'h07F7, 0, 0, 8'h00, 16'h0000); step();
        idle(); step();
        clr = 1'b1;
        drive(1, 0, 8'h7F, 16'h0000, 0, 0, 8'h00, 16'h0000); step();
        clr = 1'b0;
        chk("clr_en_rv1", a_rvalid_1, 1);
        chk("clr_en_dout1", a_dout_1, 16'h07F7);
        chk("clr_busy", a_busy, 1);
        idle();
        repeat (50) step();
        clr = 1'b1;
        drive(1, 1, 8'h55, 16'h1234, 1, 0, 8'h55, 16'h0000); step();
        clr = 1'b0;
        n = 0;
        while (a_busy && n < 300) begin
            step(); n++;
            if (a_busy) chk("busy_rv", {a_rvalid_1, a_rvalid_2, b_rvalid_1, b_rvalid_2}, 0);
        end
        chk("clr_len_restart", n, 128);
        chk("busy_b_fall", b_busy, 0);
        chk("busy_fall_rv", a_rvalid_1, 0);
        drive(1, 0, 8'h00, 16'h0000, 1, 0, 8'hFF, 16'h0000); step();
        chk("cleared_rv1", a_rvalid_1, 1);
        chk("cleared_00", a_dout_1, 0);
        chk("cleared_ff", a_dout_2, 0);
        drive(1, 0, 8'h7F, 16'h0000, 1, 0, 8'h55, 16'h0000); step();
        chk("cleared_7f", a_dout_1, 0);
        chk("cleared_55", a_dout_2, 0);

        // rst in the middle of a clear restarts the sweep.
        idle();
        clr = 1'b1; step(); clr = 1'b0;
        repeat (10) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_dout", a_dout_1, 0);
        n = 0;
        while (a_busy && n < 300) begin step(); n++; end
        chk("clr_len_rst_mid", n, 128);

        // Random mixed traffic against the model.
        idle(); step(); step();
        foreach (mm[i]) mm[i] = 16'h0000;
        {ea_v_1, ea_v_2, eb_v_1, eb_v_2, sb_v_1, sb_v_2} = '0;
        {ea_d_1, ea_d_2, eb_d_1, eb_d_2, sb_d_1, sb_d_2} = '0;
        model_on = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            en_1   = ($urandom_range(0, 9) < 7);
            we_1   = 1'($urandom_range(0, 1));
            addr_1 = 8'($urandom_range(0, (i % 4 == 0) ? 255 : 15));
            din_1  = 16'($urandom_range(0, KYBER_Q - 1));
            en_2   = ($urandom_range(0, 9) < 7);
            we_2   = 1'($urandom_range(0, 1));
            addr_2 = 8'($urandom_range(0, (i % 4 == 1) ? 255 : 15));
            din_2  = 16'($urandom_range(0, KYBER_Q - 1));
            step();
            chk("rnd_a_rv1", a_rvalid_1, ea_v_1);
            chk("rnd_a_do1", a_dout_1, ea_d_1);
            chk("rnd_a_rv2", a_rvalid_2, ea_v_2);
            chk("rnd_a_do2", a_dout_2, ea_d_2);
            chk("rnd_b_rv1", b_rvalid_1, eb_v_1);
            chk("rnd_b_do1", b_dout_1, eb_d_1);
            chk("rnd_b_rv2", b_rvalid_2, eb_v_2);
            chk("rnd_b_do2", b_dout_2, eb_d_2);
            chk("rnd_coll_a", a_coll, e_coll);
            chk("rnd_coll_b", b_coll, e_coll);
        end
        model_on = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
